// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcode, result-select and control-bundle definitions
package core_pkg;

  typedef enum logic [2:0] {
    OP_A = 3'b000,
    OP_B = 3'b001,
    OP_C = 3'b010,
    OP_D = 3'b011,
    OP_E = 3'b100,
    OP_F = 3'b101,
    OP_G = 3'b110,
    OP_H = 3'b111
  } op_type_e;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       jump_cond;
    logic       alu_src;
    logic       imm_sign_extend;
    logic       imm_is_upper;
    logic       imm_sel_21;
    logic [2:0] alu_control;
    logic [1:0] result_src;
  } ctrl_t;

endpackage

// File: rtl/decode_lut.sv
// rtl/decode_lut.sv - combinational opcode/function decode into the control bundle
module decode_lut
  import core_pkg::*;
(
  input  logic [2:0]  op_t,
  input  logic [2:0]  func3,
  input  logic [10:0] func11,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic        vec_op
);

  ctrl_t raw;

  always_comb begin
    raw     = '0;
    illegal = 1'b0;
    vec_op  = 1'b0;
    case (op_type_e'(op_t))
      OP_A: begin
        raw.reg_write   = 1'b1;
        raw.alu_control = func3;
        illegal         = (func11 != '0);
      end
      OP_B: begin
        raw.reg_write       = 1'b1;
        raw.alu_src         = 1'b1;
        raw.imm_sign_extend = 1'b1;
        raw.alu_control     = func3;
      end
      OP_C: begin
        if (func3 == 3'b000) begin
          raw.reg_write    = 1'b1;
          raw.imm_is_upper = 1'b1;
          raw.imm_sel_21   = 1'b1;
          raw.result_src   = RES_IMM;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_D: begin
        raw.alu_src         = 1'b1;
        raw.imm_sign_extend = 1'b1;
        raw.alu_control     = ALU_ADD;
        if (!func3[0]) begin
          raw.reg_write  = 1'b1;
          raw.result_src = RES_MEM;
        end else begin
          raw.mem_write = 1'b1;
        end
      end
      OP_E: begin
        if (func3 == 3'b000) begin
          raw.jump       = 1'b1;
          raw.reg_write  = 1'b1;
          raw.imm_sel_21 = 1'b1;
          raw.result_src = RES_PC4;
        end else begin
          raw.jump_cond       = 1'b1;
          raw.imm_sign_extend = 1'b1;
          raw.alu_control     = func3;
        end
      end
      OP_F: begin
        vec_op          = 1'b1;
        raw.reg_write   = 1'b1;
        raw.alu_control = func3;
      end
      OP_G: begin
        vec_op              = 1'b1;
        raw.reg_write       = 1'b1;
        raw.alu_src         = 1'b1;
        raw.imm_sign_extend = 1'b1;
        raw.alu_control     = func3;
      end
      default: illegal = 1'b1;
    endcase
  end

  // an illegal instruction must never write state or redirect the PC
  always_comb begin
    ctrl = raw;
    if (illegal) begin
      ctrl.reg_write = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.jump      = 1'b0;
      ctrl.jump_cond = 1'b0;
    end
  end

endmodule

// File: rtl/vec_seq_control_unit.sv
// rtl/vec_seq_control_unit.sv - registered control unit sequencing vector ops over lane beats
module vec_seq_control_unit
  import core_pkg::*;
#(
  parameter int LANES = 4,
  parameter int VLEN  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          op_t,
  input  logic [2:0]          func3,
  input  logic [10:0]         func11,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                reg_write,
  output logic                mem_write,
  output logic                jump,
  output logic                jump_cond,
  output logic                alu_src,
  output logic                imm_sign_extend,
  output logic                imm_is_upper,
  output logic                imm_sel_21,
  output logic [2:0]          alu_control,
  output logic [1:0]          result_src,
  output logic                vec_op,
  output logic [LANES-1:0]    lane_mask,
  output logic [((VLEN/LANES) > 1 ? $clog2(VLEN/LANES) : 1)-1:0] beat_idx,
  output logic                last_beat,
  output logic                illegal
);

  localparam int VL_W   = $clog2(VLEN);
  localparam int BEATS  = VLEN / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LOG_L  = $clog2(LANES);

  typedef enum logic [1:0] {IDLE = 2'd0, SCALAR = 2'd1, VEC = 2'd2} state_e;

  typedef struct packed {
    state_e             state;
    logic               valid;
    ctrl_t              ctrl;
    logic               illegal;
    logic               vec;
    logic [LANES-1:0]   mask;
    logic [BEAT_W-1:0]  beat;
    logic               last;
    logic [BEAT_W-1:0]  last_idx;
    logic [LANES-1:0]   final_mask;
  } seq_t;

  seq_t  sq;
  ctrl_t dec_ctrl;
  logic  dec_illegal;
  logic  dec_vec;
  logic  accept;
  logic  transfer;

  decode_lut u_decode (
    .op_t    (op_t),
    .func3   (func3),
    .func11  (func11),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal),
    .vec_op  (dec_vec)
  );

  // vl of zero encodes the full vector length
  logic [VL_W-1:0]   vl_field;
  logic [VL_W:0]     vl_eff;
  logic [VL_W:0]     vl_m1;
  logic [BEAT_W-1:0] acc_last_idx;
  logic [LANES-1:0]  acc_final_mask;
  int                rem;

  assign vl_field     = func11[VL_W-1:0];
  assign vl_eff       = (vl_field == '0) ? (VL_W+1)'(VLEN) : {1'b0, vl_field};
  assign vl_m1        = vl_eff - (VL_W+1)'(1);
  assign acc_last_idx = BEAT_W'(vl_m1 >> LOG_L);

  always_comb begin
    acc_final_mask = '0;
    rem            = int'(vl_eff) % LANES;
    for (int i = 0; i < LANES; i++) begin
      acc_final_mask[i] = (rem == 0) || (i < rem);
    end
  end

  assign in_ready = !sq.valid || (out_ready && sq.last);
  assign accept   = in_valid && in_ready && !flush;
  assign transfer = sq.valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq <= '0;
    end else if (flush) begin
      sq <= '0;
    end else if (accept) begin
      sq.valid   <= 1'b1;
      sq.ctrl    <= dec_ctrl;
      sq.illegal <= dec_illegal;
      sq.vec     <= dec_vec;
      sq.beat    <= '0;
      if (dec_vec) begin
        sq.state      <= VEC;
        sq.last_idx   <= acc_last_idx;
        sq.final_mask <= acc_final_mask;
        sq.last       <= (acc_last_idx == '0);
        sq.mask       <= (acc_last_idx == '0) ? acc_final_mask : '1;
      end else begin
        sq.state      <= SCALAR;
        sq.last_idx   <= '0;
        sq.final_mask <= '0;
        sq.last       <= 1'b1;
        sq.mask       <= LANES'(1);
      end
    end else if (transfer) begin
      if (sq.state == VEC && !sq.last) begin
        sq.beat <= sq.beat + BEAT_W'(1);
        sq.last <= ((sq.beat + BEAT_W'(1)) == sq.last_idx);
        sq.mask <= ((sq.beat + BEAT_W'(1)) == sq.last_idx) ? sq.final_mask : '1;
      end else begin
        sq <= '0;
      end
    end
  end

  assign out_valid       = sq.valid;
  assign reg_write       = sq.ctrl.reg_write;
  assign mem_write       = sq.ctrl.mem_write;
  assign jump            = sq.ctrl.jump;
  assign jump_cond       = sq.ctrl.jump_cond;
  assign alu_src         = sq.ctrl.alu_src;
  assign imm_sign_extend = sq.ctrl.imm_sign_extend;
  assign imm_is_upper    = sq.ctrl.imm_is_upper;
  assign imm_sel_21      = sq.ctrl.imm_sel_21;
  assign alu_control     = sq.ctrl.alu_control;
  assign result_src      = sq.ctrl.result_src;
  assign vec_op          = sq.vec;
  assign lane_mask       = sq.mask;
  assign beat_idx        = sq.beat;
  assign last_beat       = sq.last;
  assign illegal         = sq.illegal;

endmodule

// File: tb/tb_vec_seq_control_unit.sv
// tb/tb_vec_seq_control_unit.sv - self-checking bench for vec_seq_control_unit
`timescale 1ns/1ps
module tb_vec_seq_control_unit;

  localparam int LANES  = 4;
  localparam int VLEN   = 16;
  localparam int BEAT_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        op_t = '0;
  logic [2:0]        func3 = '0;
  logic [10:0]       func11 = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              reg_write, mem_write, jump, jump_cond, alu_src;
  logic              imm_sign_extend, imm_is_upper, imm_sel_21;
  logic [2:0]        alu_control;
  logic [1:0]        result_src;
  logic              vec_op;
  logic [LANES-1:0]  lane_mask;
  logic [BEAT_W-1:0] beat_idx;
  logic              last_beat;
  logic              illegal;

  always #5 clk = ~clk;

  vec_seq_control_unit #(.LANES(LANES), .VLEN(VLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_t(op_t), .func3(func3), .func11(func11), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .reg_write(reg_write), .mem_write(mem_write), .jump(jump), .jump_cond(jump_cond),
    .alu_src(alu_src), .imm_sign_extend(imm_sign_extend), .imm_is_upper(imm_is_upper),
    .imm_sel_21(imm_sel_21), .alu_control(alu_control), .result_src(result_src),
    .vec_op(vec_op), .lane_mask(lane_mask), .beat_idx(beat_idx),
    .last_beat(last_beat), .illegal(illegal)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {rw,mw,j,jc,as,ise,iu,i21, alu[3], rs[2], vec, ill}
  function automatic logic [14:0] mk(input logic [7:0] flags, input logic [2:0] alu,
                                     input logic [1:0] rs, input logic vec, input logic ill);
    return {flags, alu, rs, vec, ill};
  endfunction

  function automatic logic [14:0] obs();
    return {reg_write, mem_write, jump, jump_cond, alu_src, imm_sign_extend, imm_is_upper,
            imm_sel_21, alu_control, result_src, vec_op, illegal};
  endfunction

  function automatic logic [14:0] ref_decode(input logic [2:0] op, input logic [2:0] f3,
                                             input logic [10:0] f11);
    logic rw, mw, j, jc, as, ise, iu, i21, vec, ill;
    logic [2:0] alu;
    logic [1:0] rs;
    {rw, mw, j, jc, as, ise, iu, i21, vec, ill} = '0;
    alu = 3'd0;
    rs  = 2'd0;
    if (op == 3'd0) begin
      rw = 1; alu = f3; ill = (f11 != 0);
    end else if (op == 3'd1) begin
      rw = 1; as = 1; ise = 1; alu = f3;
    end else if (op == 3'd2) begin
      if (f3 == 0) begin rw = 1; iu = 1; i21 = 1; rs = 2'b11; end
      else ill = 1;
    end else if (op == 3'd3) begin
      as = 1; ise = 1;
      if (f3[0]) mw = 1;
      else begin rw = 1; rs = 2'b01; end
    end else if (op == 3'd4) begin
      if (f3 == 0) begin j = 1; rw = 1; i21 = 1; rs = 2'b10; end
      else begin jc = 1; ise = 1; alu = f3; end
    end else if (op == 3'd5) begin
      vec = 1; rw = 1; alu = f3;
    end else if (op == 3'd6) begin
      vec = 1; rw = 1; as = 1; ise = 1; alu = f3;
    end else begin
      ill = 1;
    end
    if (ill) begin rw = 0; mw = 0; j = 0; jc = 0; end
    return {rw, mw, j, jc, as, ise, iu, i21, alu, rs, vec, ill};
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  f3;
    logic [10:0] f11;
    logic [14:0] exp;
  } vec_t;

  typedef struct {
    logic [14:0] b;
    logic [3:0]  mask;
    int          idx;
    bit          last;
  } beat_t;

  vec_t  tbl[10];
  beat_t q[$];

  task automatic present(input logic [2:0] op, input logic [2:0] f3, input logic [10:0] f11);
    in_valid = 1'b1; op_t = op; func3 = f3; func11 = f11;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [22:0] snap;
    int seen;

    tbl[0] = '{3'd1, 3'b011, 11'd0,     mk(8'b1000_1100, 3'b011, 2'b00, 0, 0)};
    tbl[1] = '{3'd0, 3'b010, 11'd1,     mk(8'b0000_0000, 3'b010, 2'b00, 0, 1)};
    tbl[2] = '{3'd0, 3'b101, 11'd0,     mk(8'b1000_0000, 3'b101, 2'b00, 0, 0)};
    tbl[3] = '{3'd2, 3'b000, 11'h7ff,   mk(8'b1000_0011, 3'b000, 2'b11, 0, 0)};
    tbl[4] = '{3'd2, 3'b001, 11'd0,     mk(8'b0000_0000, 3'b000, 2'b00, 0, 1)};
    tbl[5] = '{3'd3, 3'b110, 11'd3,     mk(8'b1000_1100, 3'b000, 2'b01, 0, 0)};
    tbl[6] = '{3'd3, 3'b011, 11'd0,     mk(8'b0100_1100, 3'b000, 2'b00, 0, 0)};
    tbl[7] = '{3'd4, 3'b000, 11'd0,     mk(8'b1010_0001, 3'b000, 2'b10, 0, 0)};
    tbl[8] = '{3'd4, 3'b101, 11'd0,     mk(8'b0001_0100, 3'b101, 2'b00, 0, 0)};
    tbl[9] = '{3'd7, 3'b111, 11'd0,     mk(8'b0000_0000, 3'b000, 2'b00, 0, 1)};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset in_ready", 32'(in_ready), 1);
    chk("reset ctrl", 32'(obs()), 0);
    chk("reset lane_mask/beat/last", {lane_mask, beat_idx, last_beat}, 0);
    rst_n = 1'b1;

    // scalar table, presented back to back
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; op_t = tbl[i].op; func3 = tbl[i].f3; func11 = tbl[i].f11;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d out_valid", i), 32'(out_valid), 1);
      chk($sformatf("tbl%0d ctrl", i), 32'(obs()), 32'(tbl[i].exp));
      chk($sformatf("tbl%0d mask/beat/last", i), {lane_mask, beat_idx, last_beat}, {4'b0001, 2'd0, 1'b1});
      chk($sformatf("tbl%0d in_ready", i), 32'(in_ready), 1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("tbl drain out_valid", 32'(out_valid), 0);

    // full vector, vl = 0 means 16
    present(3'd5, 3'b010, 11'd0);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("full b%0d valid/vec", b), {out_valid, vec_op}, 2'b11);
      chk($sformatf("full b%0d mask/beat/last", b), {lane_mask, beat_idx, last_beat},
          {4'hF, 2'(b), (b == 3) ? 1'b1 : 1'b0});
      chk($sformatf("full b%0d in_ready", b), 32'(in_ready), (b == 3) ? 1 : 0);
      @(posedge clk); #1;
    end
    chk("full end out_valid", 32'(out_valid), 0);

    // partial vector, vl = 6
    present(3'd6, 3'b001, 11'd6);
    chk("part b0", {out_valid, lane_mask, beat_idx, last_beat}, {1'b1, 4'hF, 2'd0, 1'b0});
    @(posedge clk); #1;
    chk("part b1", {out_valid, lane_mask, beat_idx, last_beat}, {1'b1, 4'h3, 2'd1, 1'b1});
    @(posedge clk); #1;
    chk("part end out_valid", 32'(out_valid), 0);

    // backpressure on the final beat of a vl = 5 op
    present(3'd5, 3'b100, 11'd5);
    chk("bp b0 mask", 32'(lane_mask), 4'hF);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; op_t = 3'd1; func3 = 3'b001; func11 = 11'd0;
    chk("bp b1 mask/beat/last", {lane_mask, beat_idx, last_beat}, {4'b0001, 2'd1, 1'b1});
    snap = {obs(), lane_mask, beat_idx, last_beat, out_valid};
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      chk($sformatf("bp stall%0d stable", s), 32'({obs(), lane_mask, beat_idx, last_beat, out_valid}), 32'(snap));
      chk($sformatf("bp stall%0d in_ready", s), 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp next instr", {out_valid, 15'(obs())}, {1'b1, mk(8'b1000_1100, 3'b001, 2'b00, 0, 0)});
    @(posedge clk); #1;

    // flush on beat 1 of a vl = 16 op
    present(3'd5, 3'b000, 11'd0);
    @(posedge clk); #1;
    chk("flush pre beat_idx", 32'(beat_idx), 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush out_valid", 32'(out_valid), 0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("flush no further beats", seen, 0);
    present(3'd4, 3'b000, 11'd0);
    chk("post-flush jump", {out_valid, jump, result_src}, {1'b1, 1'b1, 2'b10});
    @(posedge clk); #1;

    // asynchronous reset mid-vector, away from any clock edge
    present(3'd5, 3'b000, 11'd0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("areset out_valid", 32'(out_valid), 0);
    chk("areset ctrl", 32'(obs()), 0);
    chk("areset mask/beat/last", {lane_mask, beat_idx, last_beat}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("areset in_ready", {in_ready, out_valid}, 2'b10);

    // randomized traffic against the beat-queue model
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [14:0] d;
      bit          exp_valid, exp_ready;
      in_valid  = ($urandom_range(0, 2) != 0);
      op_t      = 3'($urandom_range(0, 7));
      func3     = 3'($urandom_range(0, 7));
      func11    = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      #1;
      exp_valid = (q.size() > 0);
      exp_ready = !exp_valid || (out_ready && q[0].last);
      chk("rand out_valid", 32'(out_valid), 32'(exp_valid));
      chk("rand in_ready", 32'(in_ready), 32'(exp_ready));
      if (exp_valid) begin
        chk("rand ctrl", 32'(obs()), 32'(q[0].b));
        chk("rand mask/beat/last", {lane_mask, beat_idx, last_beat},
            {q[0].mask, 2'(q[0].idx), q[0].last});
      end
      if (flush) begin
        q.delete();
      end else begin
        if (exp_valid && out_ready) void'(q.pop_front());
        if (in_valid && exp_ready) begin
          d = ref_decode(op_t, func3, func11);
          if (d[1]) begin
            int vl, nb, r;
            vl = (func11[3:0] == 0) ? VLEN : int'(func11[3:0]);
            nb = (vl + LANES - 1) / LANES;
            r  = vl % LANES;
            for (int b = 0; b < nb; b++) begin
              beat_t e;
              e.b    = d;
              e.idx  = b;
              e.last = (b == nb - 1);
              e.mask = (b < nb - 1 || r == 0) ? 4'hF : 4'((1 << r) - 1);
              q.push_back(e);
            end
          end else begin
            beat_t e;
            e.b = d; e.idx = 0; e.last = 1'b1; e.mask = 4'b0001;
            q.push_back(e);
          end
        end
      end
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
